// File: rtl/mdu_pkg.sv
// Shared MDU definitions: opcodes, default latencies and the unit's state encoding.
// The decode stage and the hazard unit import the same opcodes.
package mdu_pkg;

    localparam logic [3:0] MDU_NONE  = 4'd0;
    localparam logic [3:0] MDU_MULT  = 4'd1;
    localparam logic [3:0] MDU_MULTU = 4'd2;
    localparam logic [3:0] MDU_DIV   = 4'd3;
    localparam logic [3:0] MDU_DIVU  = 4'd4;
    localparam logic [3:0] MDU_MTHI  = 4'd5;
    localparam logic [3:0] MDU_MTLO  = 4'd6;

    localparam int unsigned MDU_MULT_LAT_DEF = 5;
    localparam int unsigned MDU_DIV_LAT_DEF  = 10;

    typedef enum logic {
        StIdle,
        StRun
    } mdu_state_e;

    // True for the opcodes that start a multi-cycle busy phase
    function automatic logic mdu_is_long_op(input logic [3:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational multiply/divide datapath. Produces the full 64-bit {hi,lo} result for the
// current opcode and flags division by zero so the shell can suppress the HI/LO write.
module mdu_arith
    import mdu_pkg::*;
(
    input  logic [3:0]  MDUOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [63:0] result,
    output logic        div_zero
);

    logic signed [31:0] w_a_s;
    logic signed [31:0] w_b_s;
    logic signed [63:0] w_prod_s;
    logic        [63:0] w_prod_u;

    assign w_a_s    = $signed(A);
    assign w_b_s    = $signed(B);
    assign w_prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    assign w_prod_u = {32'h0, A} * {32'h0, B};

    // Select the result for the decoded operation; divisions are only evaluated when B != 0
    always_comb begin
        result   = '0;
        div_zero = 1'b0;
        case (MDUOp)
            MDU_MULT:  result = w_prod_s;
            MDU_MULTU: result = w_prod_u;
            MDU_DIV: begin
                if (B == 32'h0) begin
                    div_zero = 1'b1;
                end else if (A == 32'h8000_0000 && B == 32'hFFFF_FFFF) begin
                    // Quotient overflows: wrap to the dividend, remainder is zero
                    result = {32'h0, 32'h8000_0000};
                end else begin
                    result = {w_a_s % w_b_s, w_a_s / w_b_s};
                end
            end
            MDU_DIVU: begin
                if (B == 32'h0) begin
                    div_zero = 1'b1;
                end else begin
                    result = {A % B, A / B};
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit. Holds HI/LO, runs mult/div with a fixed busy phase
// and commits the pending result when the busy counter expires.
module e_mdu
    import mdu_pkg::*;
#(
    parameter int unsigned MULT_LAT = MDU_MULT_LAT_DEF,
    parameter int unsigned DIV_LAT  = MDU_DIV_LAT_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  MDUOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int unsigned MaxLat = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int unsigned CntW   = $clog2(MaxLat + 1);

    logic [63:0]     w_result;
    logic            w_div_zero;

    mdu_state_e      r_state;
    logic [CntW-1:0] r_cnt;
    logic [31:0]     r_phi;
    logic [31:0]     r_plo;
    logic            r_pwe;   // pending result may be written (cleared on divide by zero)
    logic [31:0]     r_hi;
    logic [31:0]     r_lo;
    logic            r_busy;

    mdu_arith u_arith (
        .MDUOp    (MDUOp),
        .A        (A),
        .B        (B),
        .result   (w_result),
        .div_zero (w_div_zero)
    );

    // Control FSM, pending result and architectural HI/LO, all with registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_phi   <= '0;
            r_plo   <= '0;
            r_pwe   <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (mdu_is_long_op(MDUOp)) begin
                        r_phi   <= w_result[63:32];
                        r_plo   <= w_result[31:0];
                        r_pwe   <= ~w_div_zero;
                        r_cnt   <= ((MDUOp == MDU_MULT) || (MDUOp == MDU_MULTU))
                                   ? CntW'(MULT_LAT) : CntW'(DIV_LAT);
                        r_busy  <= 1'b1;
                        r_state <= StRun;
                    end else if (MDUOp == MDU_MTHI) begin
                        r_hi <= A;
                    end else if (MDUOp == MDU_MTLO) begin
                        r_lo <= A;
                    end
                end
                StRun: begin
                    if (r_cnt == CntW'(1)) begin
                        if (r_pwe) begin
                            r_hi <= r_phi;
                            r_lo <= r_plo;
                        end
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                        r_state <= StIdle;
                    end else begin
                        r_cnt <= r_cnt - CntW'(1);
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign Busy = r_busy;
    assign HI   = r_hi;
    assign LO   = r_lo;

    // The hazard unit must hold later MDU instructions in D while a result is pending
    a_no_op_in_run: assert property (@(posedge clk) disable iff (!reset)
        (r_state == StRun) |-> (MDUOp == MDU_NONE));

endmodule

// File: doc/e_mdu.md
# e_mdu

Execute-stage multiply/divide unit of the five-stage MIPS pipeline. It consumes the forwarded E-stage operands (true RD1 and true RD2 after forwarding muxes) together with the decoded MDU operation. It runs multi-cycle signed/unsigned multiply and divide, and holds the architectural HI/LO registers. It raises `Busy` so the hazard unit stalls later MDU instructions in D until the result is committed.

## Interface
- `MULT_LAT`, default 5: cycles `Busy` stays high for mult/multu.
- `DIV_LAT`, default 10: cycles `Busy` stays high for div/divu.
- `clk`  in  1  pipeline clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low. `reset==0` clears all state immediately.
- `MDUOp`  in  4  operation of the instruction in E: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo. Bubbles present 0.
- `A`  in  32  forwarded rs value (true RD1).
- `B`  in  32  forwarded rt value (true RD2).
- `Busy`  out  1  operation in progress.
- `HI`  out  32  HI register, read directly by mfhi.
- `LO`  out  32  LO register, read directly by mflo.

## Operation
- Two states:
  - IDLE: `Busy`=0, counter 0.
  - RUN: `Busy`=1, counter counts down.
- IDLE, on an edge where `MDUOp` is 1–4:
  - Compute the 64-bit result from A/B.
  - Latch it into pending registers `phi`/`plo`.
  - Load the counter with `MULT_LAT` or `DIV_LAT`.
  - Go to RUN.
- IDLE, on an edge where `MDUOp` is 5 or 6: write A into HI (5) or LO (6) at that edge. No busy phase.
- RUN, each edge: decrement the counter. On the edge where the counter equals 1:
  - Write `phi`/`plo` into HI/LO.
  - Set counter to 0, clear `Busy`, return to IDLE.
- Any nonzero `MDUOp` sampled while in RUN is ignored. The hazard unit guarantees none arrive; assertion-checked.
- Arithmetic rules:
  - mult: {HI,LO} = signed(A)·signed(B), full 64-bit.
  - multu: {HI,LO} = A·B as unsigned 64-bit.
  - div: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend. For 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
  - divu: unsigned quotient in LO, remainder in HI.
  - Divide by zero (B==0, div or divu): full `DIV_LAT` busy phase still occurs; HI and LO keep their previous values.
- HI/LO outputs show the old values throughout RUN.
- Reset at any time, including mid-RUN: HI=0, LO=0, `phi`=`plo`=0, counter 0, `Busy`=0, state IDLE. The pending result is discarded.

## Timing
- Reset values: `Busy`=0, `HI`=0, `LO`=0.
- Issue edge E0 (`MDUOp` 1–4 sampled):
  - `Busy` is high from after E0 through the cycle before E0+LAT.
  - HI/LO take the new value at edge E0+LAT, and `Busy` falls at the same edge.
  - mult: 5 busy cycles. div: 10 busy cycles.
- mthi/mtlo: HI/LO update at the sampling edge, so the value is visible the next cycle.
- Back-to-back issue: an op presented in the cycle right after `Busy` falls is accepted (IDLE at that edge).
- No combinational path from `A`, `B` or `MDUOp` to any output.

## Structure
- Package `mdu_pkg` holds:
  - Opcode localparams `MDU_NONE`, `MDU_MULT`, `MDU_MULTU`, `MDU_DIV`, `MDU_DIVU`, `MDU_MTHI`, `MDU_MTLO` (4-bit).
  - Default latency constants.
  - The state encoding (IDLE, RUN).
  - The decode stage and hazard unit import the same opcodes.
- One combinational sub-module, `mdu_arith`:
  - Inputs: `MDUOp`, `A`, `B`.
  - Outputs: 64-bit {hi,lo} result and a `div_zero` flag.
  - Keeps the sequential shell in `e_mdu` small.

## Test plan
- Reset: hold `reset`=0 two cycles, then release → `Busy`=0, HI=0, LO=0. Let the bench run the rest of the test plan.
- mult A=0xFFFFFFFF, B=2 → `Busy` high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFE. Repeat as multu → HI=0x00000001, LO=0xFFFFFFFE.
- div A=0xFFFFFFF9 (-7), B=2 → `Busy` high 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu A=7, B=0 after mthi 0x1234 / mtlo 0x5678 → 10 busy cycles, then HI=0x1234, LO=0x5678 unchanged.
- Overflow corner: div A=0x80000000, B=0xFFFFFFFF → LO=0x80000000, HI=0.
- mthi A=0xDEADBEEF → HI=0xDEADBEEF the next cycle, `Busy` never asserts. Then mult 3×4 issued the cycle after → HI=0, LO=12 after 5 cycles.
- Pull `reset` low in busy cycle 4 of a div → `Busy`, HI, LO go to 0 asynchronously. After release, no stale write occurs and HI/LO stay 0.
